// File: rtl/dcache_repair_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_repair_arbiter_pkg : shared types for the D-cache repair arbiter     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dcache_repair_arbiter_pkg;

  localparam int REPAIR_BLOCK_W  = 1024;
  localparam int REPAIR_OFFSET_W = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT     = 3'd2,
    FILL     = 3'd3,
    RESOLVE  = 3'd4,
    COOLDOWN = 3'd5
  } repair_arb_state_t;

  typedef enum logic {
    SRC_READ  = 1'b0,
    SRC_WRITE = 1'b1
  } repair_src_t;

endpackage
`default_nettype wire

// File: rtl/repair_grant_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | repair_grant_sel : tie-break between read and write repair requests        |
// | Macro DCACHE_ARB_RR_EN selects round-robin instead of read priority.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module repair_grant_sel
  import dcache_repair_arbiter_pkg::*;
(
`ifdef DCACHE_ARB_RR_EN
  input  logic favour,
`endif
  input  logic read_req,
  input  logic write_req,
  output logic grant_valid,
  output logic grant_src
);

  repair_src_t w_src;

  always_comb begin
    w_src = SRC_READ;
    if (write_req && !read_req) begin
      w_src = SRC_WRITE;
    end
`ifdef DCACHE_ARB_RR_EN
    else if (write_req && read_req && (favour == SRC_WRITE)) begin
      w_src = SRC_WRITE;
    end
`endif
  end

  assign grant_valid = read_req | write_req;
  assign grant_src   = w_src;

endmodule
`default_nettype wire

// File: rtl/dcache_repair_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dcache_repair_arbiter : single L2 refill path for D-cache miss repair      |
// | Optional macro DCACHE_ARB_RR_EN enables the round-robin tie pointer.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dcache_repair_arbiter
  import dcache_repair_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = REPAIR_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_repair_request,
  input  logic [ADDR_W-1:0]  missed_raddr,
  input  logic               write_repair_request,
  input  logic [ADDR_W-1:0]  missed_waddr,
  output logic               read_repair_req_acq,
  output logic               write_repair_req_acq,
  output logic               l2_req_valid,
  output logic [ADDR_W-1:0]  l2_req_addr,
  input  logic               l2_req_ready,
  input  logic               l2_resp_valid,
  input  logic [BLOCK_W-1:0] l2_resp_data,
  output logic               waddr_valid,
  output logic [ADDR_W-1:0]  waddr,
  output logic [BLOCK_W-1:0] wdata,
  output logic [BLOCK_W-1:0] wmask,
  output logic               repair_resolved
);

  localparam int c_OFFSET_W = $clog2(BLOCK_W / 8);

  repair_arb_state_t  r_state;
  repair_arb_state_t  w_next_state;
  repair_src_t        r_src;
  logic [ADDR_W-1:0]  r_addr;
  logic [BLOCK_W-1:0] r_line;
  logic               w_grant_valid;
  logic               w_grant_src;
  logic               w_busy;
`ifdef DCACHE_ARB_RR_EN
  repair_src_t        r_rr_ptr;
`endif

  repair_grant_sel u_grant_sel (
`ifdef DCACHE_ARB_RR_EN
    .favour      (r_rr_ptr),
`endif
    .read_req    (read_repair_request),
    .write_req   (write_repair_request),
    .grant_valid (w_grant_valid),
    .grant_src   (w_grant_src)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:     if (w_grant_valid) w_next_state = ISSUE;
      ISSUE:    if (l2_req_ready)  w_next_state = WAIT;
      WAIT:     if (l2_resp_valid) w_next_state = FILL;
      FILL:     w_next_state = RESOLVE;
      RESOLVE:  w_next_state = COOLDOWN;
      COOLDOWN: w_next_state = IDLE;
      default:  w_next_state = IDLE;
    endcase
  end

  // Winner and its address are frozen at grant; the line is only taken while waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_src  <= SRC_READ;
      r_addr <= '0;
      r_line <= '0;
`ifdef DCACHE_ARB_RR_EN
      r_rr_ptr <= SRC_READ;
`endif
    end else begin
      if ((r_state == IDLE) && w_grant_valid) begin
        r_src  <= repair_src_t'(w_grant_src);
        r_addr <= (w_grant_src == SRC_WRITE) ? missed_waddr : missed_raddr;
      end
      if ((r_state == WAIT) && l2_resp_valid) begin
        r_line <= l2_resp_data;
      end
`ifdef DCACHE_ARB_RR_EN
      if (r_state == RESOLVE) begin
        r_rr_ptr <= (r_src == SRC_READ) ? SRC_WRITE : SRC_READ;
      end
`endif
    end
  end

  assign w_busy = (r_state == ISSUE) || (r_state == WAIT) ||
                  (r_state == FILL)  || (r_state == RESOLVE);

  always_comb begin
    read_repair_req_acq  = w_busy && (r_src == SRC_READ);
    write_repair_req_acq = w_busy && (r_src == SRC_WRITE);
    l2_req_valid         = 1'b0;
    l2_req_addr          = '0;
    waddr_valid          = 1'b0;
    waddr                = '0;
    wdata                = '0;
    wmask                = '0;
    repair_resolved      = 1'b0;
    case (r_state)
      ISSUE: begin
        l2_req_valid = 1'b1;
        l2_req_addr  = {r_addr[ADDR_W-1:c_OFFSET_W], {c_OFFSET_W{1'b0}}};
      end
      FILL: begin
        waddr_valid = 1'b1;
        waddr       = r_addr;
        wdata       = r_line;
        wmask       = '1;
      end
      RESOLVE: repair_resolved = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_repair_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dcache_repair_arbiter : scoreboard bench for dcache_repair_arbiter      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dcache_repair_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read_repair_request = 1'b0;
  logic [31:0]   missed_raddr = '0;
  logic          write_repair_request = 1'b0;
  logic [31:0]   missed_waddr = '0;
  logic          read_repair_req_acq;
  logic          write_repair_req_acq;
  logic          l2_req_valid;
  logic [31:0]   l2_req_addr;
  logic          l2_req_ready = 1'b0;
  logic          l2_resp_valid = 1'b0;
  logic [1023:0] l2_resp_data = '0;
  logic          waddr_valid;
  logic [31:0]   waddr;
  logic [1023:0] wdata;
  logic [1023:0] wmask;
  logic          repair_resolved;

  dcache_repair_arbiter dut (
    .clk(clk), .rst(rst),
    .read_repair_request(read_repair_request), .missed_raddr(missed_raddr),
    .write_repair_request(write_repair_request), .missed_waddr(missed_waddr),
    .read_repair_req_acq(read_repair_req_acq), .write_repair_req_acq(write_repair_req_acq),
    .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_ready(l2_req_ready),
    .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
    .waddr_valid(waddr_valid), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .repair_resolved(repair_resolved)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0]   q_req_addr[$];
  logic [31:0]   q_fill_addr[$];
  logic [1023:0] q_fill_data[$];
  logic          q_res_src[$];   // 0 = read owner, 1 = write owner

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got %h expected no such event", name, act);
  endtask

  function automatic logic [1023:0] make_line(input logic [31:0] seed);
    return {32{seed}};
  endfunction

  task automatic expect_repair(input logic [31:0] a, input logic src, input logic [1023:0] d);
    q_req_addr.push_back({a[31:7], 7'd0});
    q_fill_addr.push_back(a);
    q_fill_data.push_back(d);
    q_res_src.push_back(src);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  logic          prev_fill = 1'b0;
  logic [31:0]   m_addr;
  logic [1023:0] m_data;
  logic          m_src;
  always @(negedge clk) begin
    if (rst) begin
      chk("acq_exclusive", 64'(read_repair_req_acq & write_repair_req_acq), 64'd0);
      if (l2_req_valid && l2_req_ready) begin
        if (q_req_addr.size() == 0) fail_now("unexpected_l2_req", 64'(l2_req_addr));
        else begin
          m_addr = q_req_addr.pop_front();
          chk("l2_req_addr", 64'(l2_req_addr), 64'(m_addr));
        end
      end
      if (waddr_valid) begin
        chk("fill_mask_ones", 64'(&wmask), 64'd1);
        if (q_fill_addr.size() == 0) fail_now("unexpected_fill", 64'(waddr));
        else begin
          m_addr = q_fill_addr.pop_front();
          m_data = q_fill_data.pop_front();
          chk("fill_waddr", 64'(waddr), 64'(m_addr));
          n_checks++;
          if (wdata !== m_data) begin
            n_errors++;
            $display("FAIL fill_wdata: got low %h expected low %h", wdata[63:0], m_data[63:0]);
          end
        end
      end else begin
        chk("mask_zero_outside_fill", 64'(|wmask), 64'd0);
      end
      if (repair_resolved) begin
        chk("resolved_after_fill", 64'(prev_fill), 64'd1);
        if (q_res_src.size() == 0) fail_now("unexpected_resolved", 64'd1);
        else begin
          m_src = q_res_src.pop_front();
          chk("resolved_owner_acq", 64'({write_repair_req_acq, read_repair_req_acq}),
              m_src ? 64'd2 : 64'd1);
        end
      end
      prev_fill = waddr_valid;
    end else begin
      prev_fill = 1'b0;
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req_valid();
    int n = 0;
    wait_cycle();
    while (!l2_req_valid && n < 50) begin
      wait_cycle();
      n++;
    end
    if (!l2_req_valid) fail_now("timeout_l2_req_valid", 64'd0);
  endtask

  // L2 side: hold ready low rdy_wait cycles, then return the line rsp_wait cycles after accept.
  task automatic serve(input int rdy_wait, input int rsp_wait, input logic [1023:0] d,
                       input logic [31:0] a_aligned);
    wait_req_valid();
    for (int i = 0; i < rdy_wait; i++) begin
      chk("req_hold_valid", 64'(l2_req_valid), 64'd1);
      chk("req_hold_addr", 64'(l2_req_addr), 64'(a_aligned));
      wait_cycle();
    end
    l2_req_ready = 1'b1;
    wait_cycle();
    l2_req_ready = 1'b0;
    chk("wait_entered_on_accept", 64'(l2_req_valid), 64'd0);
    repeat (rsp_wait) wait_cycle();
    l2_resp_valid = 1'b1;
    l2_resp_data  = d;
    wait_cycle();
    l2_resp_valid = 1'b0;
    l2_resp_data  = '0;
  endtask

  task automatic wait_resolved(output int at);
    int n = 0;
    while (!repair_resolved && n < 50) begin
      wait_cycle();
      n++;
    end
    if (!repair_resolved) fail_now("timeout_resolved", 64'd0);
    at = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int t1;

    // Reset state
    repeat (3) wait_cycle();
    chk("reset_outputs", 64'({read_repair_req_acq, write_repair_req_acq, l2_req_valid,
                              waddr_valid, repair_resolved}), 64'd0);
    chk("reset_l2_addr", 64'(l2_req_addr), 64'd0);
    rst = 1'b1;
    wait_cycle();

    // 1: read miss only, response three cycles after accept
    missed_raddr = 32'hAABB_CCDD;
    read_repair_request = 1'b1;
    expect_repair(32'hAABB_CCDD, 1'b0, make_line(32'h1111_0001));
    t0 = cyc;
    serve(0, 3, make_line(32'h1111_0001), 32'hAABB_CC80);
    wait_resolved(t1);
    chk("t1_latency", 64'(t1 - t0), 64'd7);
    read_repair_request = 1'b0;
    repeat (3) wait_cycle();

    // 2/6: simultaneous requests, both held across the first service
    missed_raddr = 32'hAABB_CCDD;
    missed_waddr = 32'hEEEE_FFFF;
    read_repair_request  = 1'b1;
    write_repair_request = 1'b1;
    expect_repair(32'hAABB_CCDD, 1'b0, make_line(32'h2222_0001));
    wait_req_valid();
    chk("t2_read_acq_first", 64'({write_repair_req_acq, read_repair_req_acq}), 64'd1);
    serve(0, 1, make_line(32'h2222_0001), 32'hAABB_CC80);
    wait_resolved(t1);
    chk("t2_write_acq_low_at_resolve", 64'(write_repair_req_acq), 64'd0);
`ifdef DCACHE_ARB_RR_EN
    expect_repair(32'hEEEE_FFFF, 1'b1, make_line(32'h2222_0002));
    serve(0, 1, make_line(32'h2222_0002), 32'hEEEE_FF80);
    wait_resolved(t1);
    write_repair_request = 1'b0;
    expect_repair(32'hAABB_CCDD, 1'b0, make_line(32'h2222_0003));
    serve(0, 1, make_line(32'h2222_0003), 32'hAABB_CC80);
    wait_resolved(t1);
    read_repair_request = 1'b0;
`else
    expect_repair(32'hAABB_CCDD, 1'b0, make_line(32'h2222_0002));
    serve(0, 1, make_line(32'h2222_0002), 32'hAABB_CC80);
    wait_resolved(t1);
    chk("t6_write_still_unacked", 64'(write_repair_req_acq), 64'd0);
    read_repair_request = 1'b0;
    expect_repair(32'hEEEE_FFFF, 1'b1, make_line(32'h2222_0003));
    serve(0, 1, make_line(32'h2222_0003), 32'hEEEE_FF80);
    wait_resolved(t1);
    write_repair_request = 1'b0;
`endif
    repeat (3) wait_cycle();

    // 3: write owns the path, L2 response toggles while still in ISSUE
    missed_waddr = 32'hEEEE_FFFF;
    write_repair_request = 1'b1;
    expect_repair(32'hEEEE_FFFF, 1'b1, make_line(32'h3333_0001));
    wait_req_valid();
    missed_raddr = 32'hAABB_CCDD;
    read_repair_request = 1'b1;
    for (int i = 0; i < 4; i++) begin
      l2_resp_valid = ~l2_resp_valid;
      l2_resp_data  = make_line(32'hDEAD_0000 + 32'(i));
      wait_cycle();
      chk("t3_no_fill_in_issue", 64'(waddr_valid), 64'd0);
      chk("t3_acq_write_only", 64'({write_repair_req_acq, read_repair_req_acq}), 64'd2);
    end
    l2_resp_valid = 1'b0;
    l2_resp_data  = '0;
    serve(0, 1, make_line(32'h3333_0001), 32'hEEEE_FF80);
    wait_resolved(t1);
    write_repair_request = 1'b0;
    expect_repair(32'hAABB_CCDD, 1'b0, make_line(32'h3333_0002));
    serve(0, 1, make_line(32'h3333_0002), 32'hAABB_CC80);
    wait_resolved(t1);
    read_repair_request = 1'b0;
    repeat (3) wait_cycle();

    // 4: L2 ready withheld for 10 cycles
    missed_waddr = 32'h1357_9BDF;
    write_repair_request = 1'b1;
    expect_repair(32'h1357_9BDF, 1'b1, make_line(32'h4444_0001));
    t0 = cyc;
    serve(10, 1, make_line(32'h4444_0001), 32'h1357_9B80);
    wait_resolved(t1);
    chk("t4_latency", 64'(t1 - t0), 64'd15);
    write_repair_request = 1'b0;
    repeat (3) wait_cycle();

    // 5: reset asserted while waiting for the line
    missed_raddr = 32'h1234_5678;
    read_repair_request = 1'b1;
    q_req_addr.push_back(32'h1234_5600);
    wait_req_valid();
    l2_req_ready = 1'b1;
    wait_cycle();
    l2_req_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("t5_async_outputs", 64'({read_repair_req_acq, write_repair_req_acq, l2_req_valid,
                                 waddr_valid, repair_resolved}), 64'd0);
    chk("t5_async_l2_addr", 64'(l2_req_addr), 64'd0);
    read_repair_request = 1'b0;
    l2_resp_valid = 1'b1;
    l2_resp_data  = make_line(32'hBAD0_BAD0);
    repeat (2) wait_cycle();
    rst = 1'b1;
    wait_cycle();
    l2_resp_valid = 1'b0;
    l2_resp_data  = '0;
    for (int i = 0; i < 3; i++) begin
      wait_cycle();
      chk("t5_no_spurious_fill", 64'({waddr_valid, l2_req_valid}), 64'd0);
    end
    missed_waddr = 32'h0000_1234;
    write_repair_request = 1'b1;
    expect_repair(32'h0000_1234, 1'b1, make_line(32'h5555_0001));
    t0 = cyc;
    serve(0, 1, make_line(32'h5555_0001), 32'h0000_1200);
    wait_resolved(t1);
    chk("t5_restart_latency", 64'(t1 - t0), 64'd5);
    write_repair_request = 1'b0;
    repeat (4) wait_cycle();

    chk("scoreboard_drained", 64'(q_req_addr.size() + q_fill_addr.size() + q_res_src.size()),
        64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
